// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle RISC-V control FSM: state codes,
// opcode constants and datapath select encodings.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format for an opcode; unsupported opcodes fall back to I.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      OP_LUI:    imm = IMM_U;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/main_fsm_branch_cond.sv
// Branch condition resolver: picks the taken condition for a branch funct3
// from the ALU compare flags and flags the two funct3 codes with no branch.
module main_fsm_branch_cond
  import main_fsm_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       bad_f3
);

  // Decode funct3 into a taken decision; 010/011 have no branch meaning.
  always_comb begin
    taken  = 1'b0;
    bad_f3 = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: bad_f3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback,
// drives the datapath strobes and mux selects, stalls on mem_ready.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 computed, wait for mem_ready
// DECODE   | OldPC+imm into ALUOut (branch/jal target), dispatch on op
// MEMADR   | rs1+imm address for load/store
// MEMREAD  | load access at ALUOut, wait for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | store access at ALUOut, wait for mem_ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALUOut to rd
// BRANCH   | rs1-rs2 compare, PC <- ALUOut if taken
// JAL      | PC <- ALUOut, compute OldPC+4 for rd
// LUI      | 0+imm into ALUOut
// ERROR    | unsupported instruction, illegal asserted
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal
);

  state_t state;
  state_t state_next;
  logic   taken;
  logic   bad_f3;

  main_fsm_branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (zero),
    .lt     (lt),
    .ltu    (ltu),
    .taken  (taken),
    .bad_f3 (bad_f3)
  );

  // State register; reset forces FETCH without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state and Moore outputs; everything is gated off while reset is low
  // so a store in flight drops MemWrite immediately.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUOp      = ALUOP_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_SUB;
        PCWrite    = taken & ~bad_f3;
        state_next = bad_f3 ? S_ERROR : S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA    = SRCA_ZERO;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ALUWB;
      end
      S_ERROR: begin
        illegal    = 1'b1;
        state_next = ILLEGAL_HALT ? S_ERROR : S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
    if (!reset) begin
      mem_req   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      ALUOp     = ALUOP_ADD;
      illegal   = 1'b0;
    end
  end

  // Immediate format follows the IR opcode directly, independent of state.
  always_comb begin
    ImmSrc = IMM_I;
    if (reset) ImmSrc = imm_src_of(op);
  end

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: an instruction-level model walks each instruction's
// cycle schedule and checks both parameterisations (halting / pulsing on
// illegal) every cycle, plus literal spot checks of the key scenarios.
module tb_main_fsm;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] SYS = 7'b1110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero, lt, ltu, mem_ready;

  logic       mem_req_h, MemWrite_h, IRWrite_h, PCWrite_h, RegWrite_h, AdrSrc_h, illegal_h;
  logic [1:0] ResultSrc_h, ALUSrcA_h, ALUSrcB_h, ALUOp_h;
  logic [2:0] ImmSrc_h;
  logic       mem_req_p, MemWrite_p, IRWrite_p, PCWrite_p, RegWrite_p, AdrSrc_p, illegal_p;
  logic [1:0] ResultSrc_p, ALUSrcA_p, ALUSrcB_p, ALUOp_p;
  logic [2:0] ImmSrc_p;

  main_fsm #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(mem_req_h), .MemWrite(MemWrite_h), .IRWrite(IRWrite_h),
    .PCWrite(PCWrite_h), .RegWrite(RegWrite_h), .AdrSrc(AdrSrc_h), .ResultSrc(ResultSrc_h),
    .ALUSrcA(ALUSrcA_h), .ALUSrcB(ALUSrcB_h), .ALUOp(ALUOp_h), .ImmSrc(ImmSrc_h),
    .illegal(illegal_h));

  main_fsm #(.ILLEGAL_HALT(1'b0)) dut_p (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(mem_req_p), .MemWrite(MemWrite_p), .IRWrite(IRWrite_p),
    .PCWrite(PCWrite_p), .RegWrite(RegWrite_p), .AdrSrc(AdrSrc_p), .ResultSrc(ResultSrc_p),
    .ALUSrcA(ALUSrcA_p), .ALUSrcB(ALUSrcB_p), .ALUOp(ALUOp_p), .ImmSrc(ImmSrc_p),
    .illegal(illegal_p));

  logic [17:0] act_h, act_p;
  assign act_h = {mem_req_h, MemWrite_h, IRWrite_h, PCWrite_h, RegWrite_h, AdrSrc_h,
                  ResultSrc_h, ALUSrcA_h, ALUSrcB_h, ALUOp_h, ImmSrc_h, illegal_h};
  assign act_p = {mem_req_p, MemWrite_p, IRWrite_p, PCWrite_p, RegWrite_p, AdrSrc_p,
                  ResultSrc_p, ALUSrcA_p, ALUSrcB_p, ALUOp_p, ImmSrc_p, illegal_p};

  int n_total = 0;
  int n_bad   = 0;
  bit fast    = 1'b0;

  // Immediate format from the instruction-format table.
  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == ST) return 3'b001;
    if (o == BR) return 3'b010;
    if (o == JL) return 3'b011;
    if (o == LU) return 3'b100;
    return 3'b000;
  endfunction

  // One expected output vector: strobes, selects, ImmSrc of the current op.
  function automatic logic [17:0] ov(input bit mreq, input bit mw, input bit irw, input bit pcw,
                                     input bit rw, input bit adr, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] aop, input bit ill);
    return {mreq, mw, irw, pcw, rw, adr, rs, a, b, aop, imm_of(op), ill};
  endfunction

  // Branch rule: f3[2:1] picks the flag (eq / signed / unsigned), f3[0] inverts.
  function automatic bit br_taken(input logic [2:0] f, input logic z, input logic l, input logic lu);
    bit base;
    base = f[2] ? (f[1] ? lu : l) : z;
    return base ^ f[0];
  endfunction

  function automatic bit br_valid(input logic [2:0] f);
    return f[2:1] != 2'b01;
  endfunction

  function automatic logic [17:0] e_fetch(input bit mr);
    return ov(1, 0, mr, mr, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_decode();
    return ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_memadr();
    return ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_mem(input bit wr);
    return ov(1, wr, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_wb(input bit from_mem);
    return ov(0, 0, 0, 0, 1, 0, from_mem ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_exec(input bit imm);
    return ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, imm ? 2'b01 : 2'b00, 2'b10, 0);
  endfunction
  function automatic logic [17:0] e_branch(input bit pcw);
    return ov(0, 0, 0, pcw, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
  endfunction
  function automatic logic [17:0] e_jal();
    return ov(0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_lui();
    return ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00, 0);
  endfunction
  function automatic logic [17:0] e_err();
    return ov(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
  endfunction

  // Compare both DUTs at the falling edge, then advance to just after the next rising edge.
  task automatic tick(input logic [17:0] eh, input logic [17:0] ep);
    @(negedge clk);
    n_total++;
    if (act_h !== eh) begin
      n_bad++;
      $display("FAIL cycle_halt t=%0t op=%b got=%h want=%h", $time, op, act_h, eh);
    end
    n_total++;
    if (act_p !== ep) begin
      n_bad++;
      $display("FAIL cycle_pulse t=%0t op=%b got=%h want=%h", $time, op, act_p, ep);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  task automatic rnd_flags();
    zero = 1'($urandom_range(0, 1));
    lt   = 1'($urandom_range(0, 1));
    ltu  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_inputs();
    mem_ready = 1'($urandom_range(0, 1));
    rnd_flags();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick(18'h0, 18'h0);
    reset = 1'b1;
  endtask

  task automatic fetch_phase();
    bit mr;
    for (int n = 0; n < 8; n++) begin
      mr = (fast || n >= 5) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      mem_ready = mr;
      rnd_flags();
      tick(e_fetch(mr), e_fetch(mr));
      if (mr) return;
    end
  endtask

  task automatic mem_phase(input bit wr, output bit aborted);
    bit mr;
    aborted = 1'b0;
    for (int n = 0; n < 8; n++) begin
      mr = (fast || n >= 5) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      mem_ready = mr;
      rnd_flags();
      tick(e_mem(wr), e_mem(wr));
      if (mr) return;
      if (!fast && $urandom_range(0, 9) == 0) begin
        do_reset();
        aborted = 1'b1;
        return;
      end
    end
  endtask

  // Error entry: both flag illegal, then the halting copy holds while the
  // pulsing copy is back in FETCH; a reset realigns them.
  task automatic err_phase();
    idle_inputs();
    tick(e_err(), e_err());
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b0;
      rnd_flags();
      #1;
      lit("illegal_held", {31'd0, illegal_h}, 32'd1);
      lit("illegal_pulse_gone", {31'd0, illegal_p}, 32'd0);
      tick(e_err(), e_fetch(1'b0));
    end
    do_reset();
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3);
    bit ab, tk;
    op = o;
    funct3 = f3;
    fetch_phase();
    idle_inputs();
    tick(e_decode(), e_decode());
    case (o)
      LD, ST: begin
        idle_inputs();
        tick(e_memadr(), e_memadr());
        mem_phase(o == ST, ab);
        if (!ab && o == LD) begin
          idle_inputs();
          tick(e_wb(1), e_wb(1));
        end
      end
      RT, IT: begin
        idle_inputs();
        tick(e_exec(o == IT), e_exec(o == IT));
        idle_inputs();
        tick(e_wb(0), e_wb(0));
      end
      BR: begin
        idle_inputs();
        tk = br_valid(f3) && br_taken(f3, zero, lt, ltu);
        tick(e_branch(tk), e_branch(tk));
        if (!br_valid(f3)) err_phase();
      end
      JL, LU: begin
        idle_inputs();
        tick(o == JL ? e_jal() : e_lui(), o == JL ? e_jal() : e_lui());
        idle_inputs();
        tick(e_wb(0), e_wb(0));
      end
      default: err_phase();
    endcase
  endtask

  // Directed branch: fixed flags in the BRANCH cycle with a hand-given PCWrite.
  task automatic br_case(input string name, input logic [2:0] f3, input logic z,
                         input logic l, input logic lu, input bit want);
    op = BR;
    funct3 = f3;
    fetch_phase();
    idle_inputs();
    tick(e_decode(), e_decode());
    mem_ready = 1'b0;
    zero = z; lt = l; ltu = lu;
    #1;
    lit(name, {31'd0, PCWrite_h}, {31'd0, want});
    tick(e_branch(br_taken(f3, z, l, lu)), e_branch(br_taken(f3, z, l, lu)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops [8];
    logic [6:0] o;
    ops[0] = LD; ops[1] = ST; ops[2] = RT; ops[3] = IT;
    ops[4] = BR; ops[5] = JL; ops[6] = LU; ops[7] = SYS;

    reset = 1'b0; op = RT; funct3 = 3'b000;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #2;
    #1;
    lit("rst_mem_req", {31'd0, mem_req_h}, 32'd0);
    lit("rst_irwrite", {31'd0, IRWrite_h}, 32'd0);
    tick(18'h0, 18'h0);
    reset = 1'b1;

    // add with immediate memory: 4-cycle sequence
    fast = 1'b1;
    op = RT; funct3 = 3'b000;
    fetch_phase();
    idle_inputs();
    tick(e_decode(), e_decode());
    idle_inputs();
    #1;
    lit("add_aluop", {30'd0, ALUOp_h}, 32'd2);
    tick(e_exec(0), e_exec(0));
    idle_inputs();
    #1;
    lit("add_regwrite", {31'd0, RegWrite_h}, 32'd1);
    tick(e_wb(0), e_wb(0));

    // lw with memory stalled three cycles in MEMREAD
    op = LD;
    fetch_phase();
    idle_inputs();
    tick(e_decode(), e_decode());
    idle_inputs();
    tick(e_memadr(), e_memadr());
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      rnd_flags();
      #1;
      lit("lw_wait_regwrite", {31'd0, RegWrite_h}, 32'd0);
      lit("lw_wait_mem_req", {31'd0, mem_req_h}, 32'd1);
      tick(e_mem(0), e_mem(0));
    end
    idle_inputs();
    #1;
    lit("lw_memwb_regwrite", {31'd0, RegWrite_h}, 32'd1);
    tick(e_wb(1), e_wb(1));

    br_case("bne_zero1", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
    br_case("bne_zero0", 3'b001, 1'b0, 1'b1, 1'b1, 1'b1);
    br_case("bltu_ltu1", 3'b110, 1'b1, 1'b0, 1'b1, 1'b1);
    br_case("bge_lt1", 3'b101, 1'b0, 1'b1, 1'b0, 1'b0);

    // jal: PC redirect, then writeback of OldPC+4 via ALUOut
    op = JL;
    fetch_phase();
    idle_inputs();
    tick(e_decode(), e_decode());
    idle_inputs();
    #1;
    lit("jal_pcwrite", {31'd0, PCWrite_h}, 32'd1);
    tick(e_jal(), e_jal());
    idle_inputs();
    #1;
    lit("jal_wb_regwrite", {31'd0, RegWrite_h}, 32'd1);
    lit("jal_wb_resultsrc", {30'd0, ResultSrc_h}, 32'd0);
    tick(e_wb(0), e_wb(0));

    // reset during a stalled store
    op = ST;
    fetch_phase();
    idle_inputs();
    tick(e_decode(), e_decode());
    idle_inputs();
    tick(e_memadr(), e_memadr());
    mem_ready = 1'b0;
    #1;
    lit("sw_memwrite_on", {31'd0, MemWrite_h}, 32'd1);
    tick(e_mem(1), e_mem(1));
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    lit("sw_memwrite_async_off_h", {31'd0, MemWrite_h}, 32'd0);
    lit("sw_memwrite_async_off_p", {31'd0, MemWrite_p}, 32'd0);
    tick(18'h0, 18'h0);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    lit("post_rst_fetch_mem_req", {31'd0, mem_req_h}, 32'd1);
    tick(e_fetch(0), e_fetch(0));

    // unsupported opcode
    op = SYS;
    fetch_phase();
    idle_inputs();
    tick(e_decode(), e_decode());
    idle_inputs();
    #1;
    lit("sys_illegal_h", {31'd0, illegal_h}, 32'd1);
    lit("sys_illegal_p", {31'd0, illegal_p}, 32'd1);
    tick(e_err(), e_err());
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b0;
      rnd_flags();
      #1;
      lit("sys_illegal_held", {31'd0, illegal_h}, 32'd1);
      lit("sys_pulse_fetch", {31'd0, mem_req_p}, 32'd1);
      tick(e_err(), e_fetch(1'b0));
    end
    do_reset();

    // randomized instruction stream
    fast = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        o = 7'($urandom_range(0, 127));
      end else begin
        o = ops[$urandom_range(0, 7)];
      end
      run_instr(o, 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
